load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus store data and access type, from the EX stage.
- Performs one load or store at a time over a req/gnt/rvalid data-memory handshake: byte-lane steering, write strobes, load extraction/extension, alignment checking.
- Returns load data / completion to writeback and stalls EX while busy.

Parameters:
- ADDR_WIDTH, 32, width of ex_addr and mem_addr; mem_addr low 2 bits always 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX presents an operation this cycle
- ex_is_load  in  1  operation is a load
- ex_is_store  in  1  operation is a store; ex_is_load wins if both set
- ex_funct3  in  3  0 B, 1 H, 2 W, 4 BU, 5 HU
- ex_addr  in  ADDR_WIDTH  effective address (ALU result)
- ex_store_data  in  32  rs2 value
- ex_rd  in  5  load destination register
- flush  in  1  kill current/incoming operation
- lsu_busy  out  1  stall to EX; high whenever state != IDLE
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned address
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte write enables (0 for loads)
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  register write (load, no exception)
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data, else 0
- wb_exc  out  1  exception on this completion
- wb_exc_cause  out  2  01 load misaligned, 10 store misaligned, 11 illegal funct3

Behaviour:
- Reset:
  - state IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_*, lsu_busy.
  - Reset mid-transaction abandons it; no wb_valid afterwards.
- Registered outputs; FSM states IDLE, REQ, WAIT, DONE.
- IDLE: accept when ex_valid & (ex_is_load | ex_is_store) & !flush.
  - Latch op, addr, data, rd, funct3 on acceptance.
- Illegal funct3 check:
  - Illegal is load {3,6,7} or store {>=3}.
  - Illegal -> DONE with cause 11, no memory request.
- Alignment check, applied only to legal funct3:
  - H/HU/SH need addr[0]=0; W needs addr[1:0]=0.
  - Misaligned -> DONE with cause 01/10, no memory request.
- Otherwise -> REQ.
- REQ:
  - mem_req=1; mem_addr/mem_we/mem_wdata/mem_wstrb held stable until mem_gnt.
  - On gnt: store -> DONE; load -> WAIT.
  - mem_rvalid is ignored in REQ.
- Store steering:
  - SB: wdata = 4 copies of data[7:0], wstrb = 0001 << addr[1:0].
  - SH: wdata = 2 copies of data[15:0], wstrb = 0011 << addr[1:0].
  - SW: wdata = data, wstrb = 1111.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture mem_rdata and extract:
    - byte = rdata >> 8*addr[1:0]; half = rdata >> 16*addr[1].
    - B/H sign-extend; BU/HU zero-extend; W unchanged.
  - -> DONE.
- DONE:
  - wb_valid=1 for exactly one cycle.
  - wb_we=1 only for a non-excepting load; wb_rd = latched rd; wb_data = 0 for stores and exceptions.
  - -> IDLE.
- lsu_busy is derived from the next state, so it is high in the cycle after acceptance and through DONE.
- A new operation is accepted only in IDLE, so there is no back-to-back acceptance in DONE.
- Flush:
  - In IDLE: blocks acceptance.
  - In REQ before gnt: drop mem_req next cycle, -> IDLE, no wb_valid.
  - In REQ with gnt in the same cycle: treated as granted, then suppressed.
  - In WAIT: keep waiting for rvalid (response must be drained), then -> IDLE without wb_valid.
  - In DONE: suppress wb_valid.
- Latency from acceptance cycle T, with zero-wait memory:
  - store wb_valid at T+2 (gnt at T+1);
  - load wb_valid at T+3 (gnt T+1, rvalid T+2);
  - exception wb_valid at T+1.
- Memory stalls (late gnt/rvalid) extend latency cycle-for-cycle.

Test Plan:
- LB at addr 0x1003, rdata 0x80FF_7F01, gnt/rvalid zero-wait -> mem_addr 0x1000, wstrb 0, wb_valid at T+3, wb_we=1, wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH data 0xABCD_1234 at addr 0x2002, gnt delayed 3 cycles -> mem_req/addr/wdata 0x1234_1234/wstrb 1100 stable for 4 cycles, wb_valid 1 cycle after gnt, wb_we=0.
- LW at 0x0006 -> no mem_req, wb_valid at T+1, wb_exc=1, cause 01, wb_we=0; SW at 0x0001 -> cause 10; load funct3=3 -> cause 11.
- LH 0x3002 with flush asserted in WAIT, rvalid 2 cycles later -> no wb_valid, lsu_busy drops after rvalid, next op accepted normally.
- Flush in REQ before gnt -> mem_req low next cycle, back to IDLE, no wb_valid.
- rst asserted asynchronously mid-WAIT -> all outputs 0 immediately; late mem_rvalid after release ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store over a req/gnt/rvalid data-memory port
// with byte-lane steering, load extension and alignment/funct3 exception reporting.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [31:0]           ex_store_data,
    input  logic [4:0]            ex_rd,
    input  logic                  flush,
    output logic                  lsu_busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  wb_exc,
    output logic [1:0]            wb_exc_cause
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state_q, state_n;
    logic killed_q, killed_n, accept, illegal, misal, op_load, done_n, cur_load;
    logic wb_valid_q, wb_we_q;
    logic [1:0] in_cause, cause_q, cur_cause, a_q;
    logic [2:0] f3_q;
    logic [4:0] rd_q, cur_rd;
    logic [7:0] bsel;
    logic [15:0] hsel;
    logic [31:0] ext, wdata_n;
    logic [3:0] wstrb_n;
    always_comb begin
        accept = ex_valid & (ex_is_load | ex_is_store) & ~flush;
        illegal = ex_is_load ? (ex_funct3 == 3'd3 || ex_funct3[2:1] == 2'b11) : (ex_funct3 >= 3'd3);
        misal = ((ex_funct3[1:0] == 2'd1) & ex_addr[0]) | ((ex_funct3[1:0] == 2'd2) & (|ex_addr[1:0]));
        in_cause = illegal ? 2'b11 : misal ? (ex_is_load ? 2'b01 : 2'b10) : 2'b00;
        wdata_n = ex_funct3[1:0] == 2'd0 ? {4{ex_store_data[7:0]}} :
                  ex_funct3[1:0] == 2'd1 ? {2{ex_store_data[15:0]}} : ex_store_data;
        wstrb_n = ex_is_load ? 4'b0000 :
                  ex_funct3[1:0] == 2'd0 ? 4'b0001 << ex_addr[1:0] :
                  ex_funct3[1:0] == 2'd1 ? 4'b0011 << ex_addr[1:0] : 4'b1111;
        bsel = 8'(mem_rdata >> {a_q, 3'b000});
        hsel = 16'(mem_rdata >> {a_q[1], 4'b0000});
        ext = f3_q == 3'd0 ? {{24{bsel[7]}}, bsel} :
              f3_q == 3'd4 ? {24'd0, bsel} :
              f3_q == 3'd1 ? {{16{hsel[15]}}, hsel} :
              f3_q == 3'd5 ? {16'd0, hsel} : mem_rdata;
        state_n = state_q;
        case (state_q)
            IDLE: state_n = accept ? (in_cause != 2'b00 ? DONE : REQ) : IDLE;
            REQ:  state_n = mem_gnt ? (op_load ? WAIT : (flush ? IDLE : DONE)) : (flush ? IDLE : REQ);
            WAIT: state_n = mem_rvalid ? ((killed_q | flush) ? IDLE : DONE) : WAIT;
            DONE: state_n = IDLE;
        endcase
        // A load flushed at grant time still owes a response, so the kill is remembered in WAIT
        killed_n = (state_q == IDLE) ? 1'b0 : killed_q | flush;
        done_n = state_n == DONE;
        cur_load = (state_q == IDLE) ? ex_is_load : op_load;
        cur_rd = (state_q == IDLE) ? ex_rd : rd_q;
        cur_cause = (state_q == IDLE) ? in_cause : cause_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            killed_q     <= 1'b0;
            op_load      <= 1'b0;
            a_q          <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            cause_q      <= '0;
            lsu_busy     <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exc       <= 1'b0;
            wb_exc_cause <= '0;
        end else begin
            state_q  <= state_n;
            killed_q <= killed_n;
            lsu_busy <= state_n != IDLE;
            mem_req  <= state_n == REQ;
            if (state_q == IDLE && accept) begin
                op_load <= ex_is_load;
                a_q     <= ex_addr[1:0];
                f3_q    <= ex_funct3;
                rd_q    <= ex_rd;
                cause_q <= in_cause;
            end
            if (state_q == IDLE && state_n == REQ) begin
                mem_we    <= ~ex_is_load;
                mem_addr  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata <= wdata_n;
                mem_wstrb <= wstrb_n;
            end
            wb_valid_q   <= done_n;
            wb_we_q      <= done_n & cur_load & (cur_cause == 2'b00);
            wb_rd        <= done_n ? cur_rd : 5'd0;
            wb_data      <= (done_n && state_q == WAIT) ? ext : 32'd0;
            wb_exc       <= done_n & (cur_cause != 2'b00);
            wb_exc_cause <= done_n ? cur_cause : 2'b00;
        end
    end
    // Flush arriving during DONE still cancels the completion
    assign wb_valid = wb_valid_q & ~flush;
    assign wb_we    = wb_we_q & ~flush;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for load_store_unit.
module tb_load_store_unit;
    logic clk = 0, rst = 1;
    logic ex_valid = 0, ex_is_load = 0, ex_is_store = 0, flush = 0;
    logic [2:0] ex_funct3 = 0;
    logic [31:0] ex_addr = 0, ex_store_data = 0, mem_rdata = 32'h80FF_7F01;
    logic [4:0] ex_rd = 0;
    logic mem_gnt = 1, mem_rvalid = 1;
    logic lsu_busy, mem_req, mem_we, wb_valid, wb_we, wb_exc;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0] mem_wstrb;
    logic [4:0] wb_rd;
    logic [1:0] wb_exc_cause;
    int n_vec = 0, n_err = 0, wb_cnt = 0, c0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .flush(flush), .lsu_busy(lsu_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (wb_valid) wb_cnt <= wb_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic l, input logic s, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        ex_valid = 1; ex_is_load = l; ex_is_store = s; ex_funct3 = f3;
        ex_addr = a; ex_store_data = d; ex_rd = rd;
        tick();
        ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
    endtask

    task automatic wait_wb(input string tag, input int exp_lat);
        int lat = 1;
        while (!wb_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic do_op(input string tag, input logic l, input logic s, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input int lat, input logic we, input logic [31:0] data,
                         input logic exc, input logic [1:0] cause);
        issue(l, s, f3, a, d, rd);
        wait_wb(tag, lat);
        chk({tag, " wb_we"}, wb_we, we);
        chk({tag, " wb_data"}, wb_data, data);
        chk({tag, " wb_exc"}, wb_exc, exc);
        chk({tag, " cause"}, wb_exc_cause, cause);
        chk({tag, " wb_rd"}, wb_rd, rd);
        tick();
        chk({tag, " pulse"}, wb_valid, 0);
    endtask

    initial begin
        #1;
        chk("rst busy", lsu_busy, 0);
        chk("rst req", mem_req, 0);
        chk("rst addr", mem_addr, 0);
        chk("rst wdata", mem_wdata, 0);
        chk("rst wstrb", mem_wstrb, 0);
        chk("rst wb_valid", wb_valid, 0);
        tick(); tick();
        rst = 0;
        tick();

        issue(1, 0, 3'd0, 32'h1003, 0, 5'd5);
        chk("lb req", mem_req, 1);
        chk("lb addr", mem_addr, 32'h1000);
        chk("lb wstrb", mem_wstrb, 0);
        chk("lb we", mem_we, 0);
        chk("lb busy", lsu_busy, 1);
        wait_wb("lb", 3);
        chk("lb wb_we", wb_we, 1);
        chk("lb data", wb_data, 32'hFFFF_FF80);
        chk("lb rd", wb_rd, 5);
        tick();
        chk("lb pulse", wb_valid, 0);
        chk("lb idle", lsu_busy, 0);
        do_op("lbu", 1, 0, 3'd4, 32'h1003, 0, 5'd6, 3, 1, 32'h0000_0080, 0, 0);
        do_op("lb1", 1, 0, 3'd0, 32'h1001, 0, 5'd7, 3, 1, 32'h0000_007F, 0, 0);
        do_op("lh", 1, 0, 3'd1, 32'h1002, 0, 5'd8, 3, 1, 32'hFFFF_80FF, 0, 0);
        do_op("lhu", 1, 0, 3'd5, 32'h1002, 0, 5'd8, 3, 1, 32'h0000_80FF, 0, 0);
        do_op("lw", 1, 0, 3'd2, 32'h1004, 0, 5'd9, 3, 1, 32'h80FF_7F01, 0, 0);

        issue(0, 1, 3'd0, 32'h0001, 32'h0000_00AB, 5'd1);
        chk("sb wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb wstrb", mem_wstrb, 4'b0010);
        chk("sb we", mem_we, 1);
        wait_wb("sb", 2);
        chk("sb wb_we", wb_we, 0);
        tick();
        issue(0, 1, 3'd2, 32'h0008, 32'h1122_3344, 5'd1);
        chk("sw wdata", mem_wdata, 32'h1122_3344);
        chk("sw wstrb", mem_wstrb, 4'b1111);
        wait_wb("sw", 2);
        tick();

        mem_gnt = 0;
        issue(0, 1, 3'd1, 32'h2002, 32'hABCD_1234, 5'd2);
        for (int i = 0; i < 4; i++) begin
            chk("sh req", mem_req, 1);
            chk("sh addr", mem_addr, 32'h2000);
            chk("sh wdata", mem_wdata, 32'h1234_1234);
            chk("sh wstrb", mem_wstrb, 4'b1100);
            chk("sh early wb", wb_valid, 0);
            if (i == 3) mem_gnt = 1;
            tick();
        end
        chk("sh wb_valid", wb_valid, 1);
        chk("sh wb_we", wb_we, 0);
        chk("sh wb_data", wb_data, 0);
        chk("sh req drop", mem_req, 0);
        tick();
        chk("sh pulse", wb_valid, 0);

        issue(1, 0, 3'd2, 32'h0006, 0, 5'd3);
        chk("lw mis req", mem_req, 0);
        wait_wb("lw mis", 1);
        chk("lw mis exc", wb_exc, 1);
        chk("lw mis cause", wb_exc_cause, 2'b01);
        chk("lw mis we", wb_we, 0);
        tick();
        do_op("sw mis", 0, 1, 3'd2, 32'h0001, 32'h5555_5555, 5'd4, 1, 0, 0, 1, 2'b10);
        do_op("lhu mis", 1, 0, 3'd5, 32'h0003, 0, 5'd4, 1, 0, 0, 1, 2'b01);
        do_op("ld f3=3", 1, 0, 3'd3, 32'h0001, 0, 5'd10, 1, 0, 0, 1, 2'b11);
        do_op("st f3=4", 0, 1, 3'd4, 32'h0000, 0, 5'd11, 1, 0, 0, 1, 2'b11);
        do_op("both ld", 1, 1, 3'd2, 32'h0002, 0, 5'd12, 1, 0, 0, 1, 2'b01);

        c0 = wb_cnt;
        mem_rvalid = 0;
        issue(1, 0, 3'd1, 32'h3002, 0, 5'd13);
        tick();
        flush = 1;
        chk("fw busy", lsu_busy, 1);
        tick();
        flush = 0;
        tick();
        mem_rvalid = 1;
        chk("fw busy hold", lsu_busy, 1);
        tick();
        chk("fw busy drop", lsu_busy, 0);
        chk("fw no wb", wb_cnt, c0);
        do_op("after fw", 1, 0, 3'd2, 32'h3000, 0, 5'd14, 3, 1, 32'h80FF_7F01, 0, 0);

        c0 = wb_cnt;
        mem_gnt = 0;
        issue(1, 0, 3'd2, 32'h3000, 0, 5'd15);
        chk("fr req", mem_req, 1);
        flush = 1;
        tick();
        flush = 0;
        mem_gnt = 1;
        chk("fr req drop", mem_req, 0);
        chk("fr busy", lsu_busy, 0);
        tick(); tick(); tick();
        chk("fr no wb", wb_cnt, c0);

        c0 = wb_cnt;
        mem_rvalid = 0;
        issue(1, 0, 3'd2, 32'h4000, 0, 5'd9);
        tick();
        #3 rst = 1;
        #1;
        chk("ar busy", lsu_busy, 0);
        chk("ar req", mem_req, 0);
        chk("ar addr", mem_addr, 0);
        chk("ar wb_valid", wb_valid, 0);
        tick();
        rst = 0;
        mem_rvalid = 1;
        tick(); tick(); tick();
        chk("ar no wb", wb_cnt, c0);
        chk("ar idle", lsu_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
